// File: rtl/quad_pixel_packer.sv
// quad_pixel_packer: raster-to-quad front end for the 2x bilinear upscaler.
// Pixels arrive one per clock in raster order. Each even/odd line pair is
// buffered as horizontal pixel pairs. When the odd line completes, a burst of
// FRAME_WIDTH/2 quads {p(x,y), p(x+1,y), p(x,y+1), p(x+1,y+1)} is emitted.
// Optional feature macro: QPACK_RESYNC_EN. When defined, an sof inside a
// frame aborts the frame and restarts at that pixel.
module quad_pixel_packer #(
  parameter int DW            = 8,
  parameter int FRAME_WIDTH   = 40,
  parameter int FRAME_HEIGHT  = 16,
  parameter int COL_CNT_WIDTH = 12,
  parameter int ROW_CNT_WIDTH = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            sof_i,
  input  logic            pix_valid_i,
  input  logic [DW-1:0]   pix_i,
  output logic [4*DW-1:0] data_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            busy_o
);

  localparam int HALF_W = FRAME_WIDTH / 2;
  localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EVEN, S_ODD} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [COL_CNT_WIDTH-1:0] r_col;
  logic [ROW_CNT_WIDTH-1:0] r_row;
  logic [DW-1:0]            r_held;

  logic [2*DW-1:0] r_mem_a [HALF_W];
  logic [2*DW-1:0] r_mem_b [HALF_W];
  logic [2*DW-1:0] r_ram_a;
  logic [2*DW-1:0] r_ram_b;

  logic                     r_rd_active;
  logic [COL_CNT_WIDTH-1:0] r_rd_addr;
  logic                     r_rd_final;
  logic                     r_ram_vld;
  logic                     r_ram_last;
  logic                     r_out_last;
  logic                     r_hsync;
  logic [4*DW-1:0]          r_data;
  logic                     r_vsync;
  logic                     r_busy;

  logic                     w_sof_accept;
  logic                     w_pix_acc;
  logic                     w_last_col;
  logic                     w_line_end;
  logic                     w_pair_wr;
  logic                     w_burst_go;
  logic [ROW_CNT_WIDTH-1:0] w_row_nxt;
  logic                     w_frame_done;
  logic [AW-1:0]            w_wr_addr;
  logic                     w_rd_last;

`ifdef QPACK_RESYNC_EN
  assign w_sof_accept = pix_valid_i && sof_i;
`else
  assign w_sof_accept = pix_valid_i && sof_i && (r_state == S_IDLE);
`endif

  assign w_pix_acc    = pix_valid_i && (r_state != S_IDLE);
  assign w_last_col   = (r_col == COL_CNT_WIDTH'(FRAME_WIDTH - 1));
  assign w_line_end   = w_pix_acc && w_last_col && !w_sof_accept;
  assign w_pair_wr    = w_pix_acc && r_col[0] && !w_sof_accept;
  assign w_burst_go   = w_line_end && (r_state == S_ODD);
  assign w_row_nxt    = r_row + ROW_CNT_WIDTH'(2);
  assign w_frame_done = (w_row_nxt == ROW_CNT_WIDTH'(FRAME_HEIGHT));
  assign w_wr_addr    = r_col[AW:1];
  assign w_rd_last    = (r_rd_addr == COL_CNT_WIDTH'(HALF_W - 1));

  // Input FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Input FSM next-state: line completion walks EVEN -> ODD -> EVEN/IDLE
  always_comb begin
    w_state_nxt = r_state;
    if (w_sof_accept) begin
      w_state_nxt = S_EVEN;
    end else if (w_line_end) begin
      case (r_state)
        S_EVEN:  w_state_nxt = S_ODD;
        S_ODD:   w_state_nxt = w_frame_done ? S_IDLE : S_EVEN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Column/row counters and even-column pixel hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_held <= '0;
    end else if (w_sof_accept) begin
      // The sof pixel itself is column 0, so the next pixel is column 1.
      r_col  <= COL_CNT_WIDTH'(1);
      r_row  <= '0;
      r_held <= pix_i;
    end else if (w_pix_acc) begin
      if (!r_col[0]) r_held <= pix_i;
      r_col <= w_last_col ? '0 : r_col + COL_CNT_WIDTH'(1);
      if (w_burst_go) r_row <= w_row_nxt;
    end
  end

  // Line buffers: pair writes and synchronous reads (contents need no reset)
  always_ff @(posedge clk) begin
    if (w_pair_wr) begin
      if (r_state == S_EVEN) r_mem_a[w_wr_addr] <= {r_held, pix_i};
      else                   r_mem_b[w_wr_addr] <= {r_held, pix_i};
    end
    r_ram_a <= r_mem_a[r_rd_addr[AW-1:0]];
    r_ram_b <= r_mem_b[r_rd_addr[AW-1:0]];
  end

  // Burst engine: read address sweep, read pipeline and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_active <= 1'b0;
      r_rd_addr   <= '0;
      r_rd_final  <= 1'b0;
      r_ram_vld   <= 1'b0;
      r_ram_last  <= 1'b0;
      r_out_last  <= 1'b0;
      r_hsync     <= 1'b0;
      r_data      <= '0;
    end else begin
      if (w_burst_go) begin
        r_rd_active <= 1'b1;
        r_rd_addr   <= '0;
        r_rd_final  <= w_frame_done;
      end else if (r_rd_active) begin
        if (w_rd_last) r_rd_active <= 1'b0;
        else           r_rd_addr   <= r_rd_addr + COL_CNT_WIDTH'(1);
      end
      r_ram_vld  <= r_rd_active;
      r_ram_last <= r_rd_active && w_rd_last && r_rd_final;
      r_out_last <= r_ram_last;
      r_hsync    <= r_ram_vld;
      r_data     <= r_ram_vld ? {r_ram_a, r_ram_b} : '0;
    end
  end

  // Frame status: vsync pulse per accepted sof, busy until the final burst ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_vsync <= w_sof_accept;
      // A new frame already underway keeps busy high over the old final burst.
      if (w_sof_accept)                            r_busy <= 1'b1;
      else if (r_out_last && (r_state == S_IDLE))  r_busy <= 1'b0;
    end
  end

  assign data_o  = r_data;
  assign hsync_o = r_hsync;
  assign vsync_o = r_vsync;
  assign busy_o  = r_busy;

endmodule

// File: tb/tb_quad_pixel_packer.sv
// Testbench for quad_pixel_packer: 40x16 instance checked against a
// frame-array quad model, plus a 4x2 instance driven from a vector table.
`timescale 1ns/1ps
module tb_quad_pixel_packer;
  localparam int W = 40, H = 16, HW = 20, NPIX = W * H;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sof, vld;
  logic [7:0]  pix;
  logic [31:0] data;
  logic        hs, vs, busy;
  logic        s_sof, s_vld;
  logic [7:0]  s_pix;
  logic [31:0] s_data;
  logic        s_hs, s_vs, s_busy;

  always #5 clk = ~clk;

  quad_pixel_packer #(.DW(8), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
                      .COL_CNT_WIDTH(12), .ROW_CNT_WIDTH(12)) dut (
    .clk(clk), .rst_n(rst_n), .sof_i(sof), .pix_valid_i(vld), .pix_i(pix),
    .data_o(data), .hsync_o(hs), .vsync_o(vs), .busy_o(busy));

  quad_pixel_packer #(.DW(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(2),
                      .COL_CNT_WIDTH(12), .ROW_CNT_WIDTH(12)) dut_s (
    .clk(clk), .rst_n(rst_n), .sof_i(s_sof), .pix_valid_i(s_vld), .pix_i(s_pix),
    .data_o(s_data), .hsync_o(s_hs), .vsync_o(s_vs), .busy_o(s_busy));

  int tests = 0, fails = 0;

  // monitor state for the main instance
  logic [31:0] cap_q[$];
  int          blen_q[$];
  int          rise_q[$];
  logic        fall_busy_q[$];
  int          run = 0, vs_cnt = 0, busy_low_cnt = 0;
  logic        hs_d = 1'b0;
  bit          track_busy = 1'b0, arm_track = 1'b0;
  // monitor state for the small instance
  logic [31:0] s_cap_q[$];
  int          s_blen_q[$];
  int          s_run = 0, s_vs_cnt = 0;
  logic        s_hs_d = 1'b0;

  // model state
  logic [7:0]  frm [NPIX];
  logic [31:0] exp_q[$];
  int          t_edge = 0, t_pair1 = 0;
  logic        v_first;

  always @(negedge clk) begin
    if (hs) begin
      cap_q.push_back(data);
      if (!hs_d) begin rise_q.push_back(int'($time)); run = 0; end
      run++;
    end else if (hs_d) begin
      blen_q.push_back(run);
      fall_busy_q.push_back(busy);
    end
    if (vs) vs_cnt++;
    if (track_busy && !busy) busy_low_cnt++;
    hs_d = hs;
  end

  always @(negedge clk) begin
    if (s_hs) begin
      s_cap_q.push_back(s_data);
      if (!s_hs_d) s_run = 0;
      s_run++;
    end else if (s_hs_d) begin
      s_blen_q.push_back(s_run);
    end
    if (s_vs) s_vs_cnt++;
    s_hs_d = s_hs;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h", nm, act, expv);
    end
  endtask

  // Reference: quads for the first npairs row pairs of frm
  function automatic void add_quads(input int npairs);
    for (int r = 0; r < npairs; r++)
      for (int k = 0; k < HW; k++)
        exp_q.push_back({frm[2*r*W + 2*k], frm[2*r*W + 2*k + 1],
                         frm[(2*r+1)*W + 2*k], frm[(2*r+1)*W + 2*k + 1]});
  endfunction

  function automatic logic [31:0] cap_at(input int i);
    if (i < cap_q.size()) return cap_q[i];
    return 'x;
  endfunction

  task automatic clear_mon();
    cap_q.delete(); blen_q.delete(); rise_q.delete(); fall_busy_q.delete();
    exp_q.delete(); vs_cnt = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic s, input logic [7:0] p);
    sof = s; vld = 1'b1; pix = p;
    @(posedge clk);
    t_edge = int'($time);
    #1;
    sof = 1'b0; vld = 1'b0;
  endtask

  // gap_mode: 0 gapless, 1 one idle cycle per pixel, 2 random 0..2 idle cycles
  task automatic send_span(input int from, input int to, input bit first_sof, input int gap_mode);
    for (int i = from; i <= to; i++) begin
      send(first_sof && (i == from), frm[i]);
      if (i == from) begin
        v_first = vs;
        if (arm_track) begin busy_low_cnt = 0; track_busy = 1'b1; end
      end
      if (i == 2*W - 1) t_pair1 = t_edge;
      if (gap_mode == 1) idle(1);
      else if (gap_mode == 2) idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((hs || busy) && n < 400) begin @(posedge clk); #1; n++; end
    idle(3);
    check("quiet timeout", 32'(n >= 400), 32'd0);
  endtask

  task automatic check_frame(input string nm, input int nbursts, input int nvs);
    int bad = 0, badlen = 0, busy0 = 0;
    check({nm, " quad count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    foreach (exp_q[i]) if (cap_at(i) !== exp_q[i]) bad++;
    check({nm, " quads mismatched"}, 32'(bad), 32'd0);
    check({nm, " burst count"}, 32'(blen_q.size()), 32'(nbursts));
    foreach (blen_q[i]) if (blen_q[i] != HW) badlen++;
    check({nm, " bad burst lengths"}, 32'(badlen), 32'd0);
    check({nm, " vsync pulses"}, 32'(vs_cnt), 32'(nvs));
    foreach (fall_busy_q[i]) if (!fall_busy_q[i]) busy0++;
    check({nm, " busy drops at burst end"}, 32'(busy0), 32'd1);
    if (fall_busy_q.size() > 0)
      check({nm, " busy low after last burst"}, 32'(fall_busy_q[fall_busy_q.size()-1]), 32'd0);
    check({nm, " busy idle"}, 32'(busy), 32'd0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NPIX; i++) frm[i] = 8'($urandom);
  endtask

  task automatic s_send(input logic s, input logic [7:0] p);
    s_sof = s; s_vld = 1'b1; s_pix = p;
    @(posedge clk); #1;
    s_sof = 1'b0; s_vld = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  px [8];
    logic [31:0] q0;
    logic [31:0] q1;
  } vec_t;
  vec_t tbl [4];

  initial begin
    tbl[0].px = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    tbl[0].q0 = 32'h01020506; tbl[0].q1 = 32'h03040708;
    tbl[1].px = '{8'h0A, 8'h14, 8'h1E, 8'h28, 8'h32, 8'h3C, 8'h46, 8'h50};
    tbl[1].q0 = 32'h0A14323C; tbl[1].q1 = 32'h1E284650;
    tbl[2].px = '{8'hAA, 8'h55, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78};
    tbl[2].q0 = 32'hAA551234; tbl[2].q1 = 32'h00FF5678;
    tbl[3].px = '{8'h80, 8'h7F, 8'h01, 8'hFE, 8'hC3, 8'h3C, 8'hE7, 8'h18};
    tbl[3].q0 = 32'h807FC33C; tbl[3].q1 = 32'h01FEE718;

    rst_n = 1'b0; sof = 1'b0; vld = 1'b0; pix = '0;
    s_sof = 1'b0; s_vld = 1'b0; s_pix = '0;
    idle(3);
    check("reset data_o", data, 32'd0);
    check("reset hsync_o", 32'(hs), 32'd0);
    check("reset vsync_o", 32'(vs), 32'd0);
    check("reset busy_o", 32'(busy), 32'd0);
    check("reset small hsync_o", 32'(s_hs), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // gapless ramp frame
    for (int i = 0; i < NPIX; i++) frm[i] = 8'(i);
    clear_mon(); add_quads(8);
    send_span(0, NPIX-1, 1'b1, 0);
    check("vsync at s+1", 32'(v_first), 32'd1);
    wait_quiet();
    check_frame("ramp", 8, 1);
    check("ramp first quad", cap_at(0), 32'h00012829);
    check("ramp last quad burst0", cap_at(19), 32'h26274E4F);
    check("hsync rise after (39,1)", 32'((rise_q.size() > 0) ? rise_q[0] - t_pair1 : -1), 32'd25);

    // same frame, valid toggling
    clear_mon(); add_quads(8);
    send_span(0, NPIX-1, 1'b1, 1);
    wait_quiet();
    check_frame("toggle", 8, 1);

    // random pixels with random gaps
    for (int f = 0; f < 2; f++) begin
      fill_random(); clear_mon(); add_quads(8);
      send_span(0, NPIX-1, 1'b1, 2);
      wait_quiet();
      check_frame("random", 8, 1);
    end

    // back-to-back frames, no idle gap
    fill_random(); clear_mon(); add_quads(8);
    arm_track = 1'b1;
    send_span(0, NPIX-1, 1'b1, 0);
    arm_track = 1'b0;
    fill_random(); add_quads(8);
    send_span(0, NPIX-1, 1'b1, 0);
    track_busy = 1'b0;
    check("b2b busy low cycles", 32'(busy_low_cnt), 32'd0);
    wait_quiet();
    check_frame("b2b", 16, 2);

    // reset during quad 10 of row pair 3
    begin
      int n = 0;
      fill_random(); clear_mon();
      send_span(0, 8*W-1, 1'b1, 0);
      while (cap_q.size() < 71 && n < 200) begin @(negedge clk); n++; end
      check("reach quad 10 of pair 3", 32'(cap_q.size() >= 71), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst hsync_o", 32'(hs), 32'd0);
      check("async rst data_o", data, 32'd0);
      check("async rst vsync_o", 32'(vs), 32'd0);
      check("async rst busy_o", 32'(busy), 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(2);
      fill_random(); clear_mon(); add_quads(8);
      send_span(0, NPIX-1, 1'b1, 2);
      wait_quiet();
      check_frame("post-reset", 8, 1);
    end

    // sof at pixel (5,6)
    fill_random(); clear_mon();
    send_span(0, 6*W + 4, 1'b1, 0);
`ifdef QPACK_RESYNC_EN
    add_quads(3);
    send(1'b1, frm[6*W + 5]);
    frm[0] = frm[6*W + 5];
    for (int i = 1; i < NPIX; i++) frm[i] = 8'($urandom);
    add_quads(8);
    send_span(1, NPIX-1, 1'b0, 0);
    wait_quiet();
    check_frame("resync", 11, 2);
`else
    send(1'b1, frm[6*W + 5]);
    send_span(6*W + 6, NPIX-1, 1'b0, 0);
    add_quads(8);
    wait_quiet();
    check_frame("mid-frame sof ignored", 8, 1);
`endif

    // 4x2 instance from vector table
    for (int v = 0; v < 4; v++) begin
      int n = 0;
      s_cap_q.delete(); s_blen_q.delete(); s_vs_cnt = 0;
      for (int j = 0; j < 8; j++) s_send(j == 0, tbl[v].px[j]);
      while ((s_busy || s_hs) && n < 50) begin @(posedge clk); #1; n++; end
      idle(3);
      check("small quiet timeout", 32'(n >= 50), 32'd0);
      check("small quad count", 32'(s_cap_q.size()), 32'd2);
      check("small quad0", (s_cap_q.size() > 0) ? s_cap_q[0] : 32'hx, tbl[v].q0);
      check("small quad1", (s_cap_q.size() > 1) ? s_cap_q[1] : 32'hx, tbl[v].q1);
      check("small burst count", 32'(s_blen_q.size()), 32'd1);
      check("small burst length", 32'((s_blen_q.size() > 0) ? s_blen_q[0] : 0), 32'd2);
      check("small vsync pulses", 32'(s_vs_cnt), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/quad_pixel_packer.md
# quad_pixel_packer

Raster-to-quad front end for the 2x bilinear upscaler. It accepts a source frame one pixel per clock in raster order and buffers each even/odd line pair. When the odd line of a pair is complete, it emits one contiguous burst of FRAME_WIDTH/2 2x2 pixel quads on hsync_o/data_o. This is the exact input format the upscaler core expects on its hsync_in/data_in pair. It sits directly upstream of the upscaler core.

## Interface
Parameters:
- DW, 8, bits per pixel
- FRAME_WIDTH, 40, source pixels per line; even, >= 4
- FRAME_HEIGHT, 16, source lines per frame; even, >= 2
- COL_CNT_WIDTH, 12, column counter and line-buffer address width
- ROW_CNT_WIDTH, 12, row counter width

Ports:
- clk  input  1  single clock
- rst_n  input  1  asynchronous active-low reset
- sof_i  input  1  start of frame; qualified by pix_valid_i; marks pixel (0,0)
- pix_valid_i  input  1  pix_i valid this cycle; at most one pixel per clock, gaps allowed
- pix_i  input  DW  source pixel
- data_o  output  DW*4  quad {p(x,y), p(x+1,y), p(x,y+1), p(x+1,y+1)}, MSB slice first
- hsync_o  output  1  data_o valid; high for exactly FRAME_WIDTH/2 consecutive cycles per line pair
- vsync_o  output  1  one-cycle pulse, one cycle after an accepted sof
- busy_o  output  1  high from accepted sof until the final burst of the frame ends

## Operation
- Storage:
  - Line buffer A holds the even line.
  - Line buffer B holds the odd line.
  - Each buffer has FRAME_WIDTH/2 entries of 2*DW bits; entry k = {p(2k), p(2k+1)}.
  - Reads are synchronous.
- Input FSM states: IDLE, EVEN, ODD.
  - IDLE -> EVEN on pix_valid_i && sof_i. Column and row counters clear; that pixel is column 0.
  - EVEN: even-column pixels are held in a register. Each odd-column pixel writes {held, pix_i} into A at column/2. After the pixel at column FRAME_WIDTH-1, go to ODD.
  - ODD: same pair assembly, writing into B. After the pixel at column FRAME_WIDTH-1:
    - trigger a burst;
    - row += 2;
    - go to EVEN, or to IDLE if the new row == FRAME_HEIGHT.
  - pix_valid_i low: counters and FSM hold.
  - sof_i in EVEN/ODD: see Configuration.
- Burst engine:
  - Independent read counter rd_addr, stepping 0 .. FRAME_WIDTH/2-1 on consecutive cycles.
  - Reads A and B at the same address and registers data_o = {A.hi, A.lo, B.hi, B.lo}.
  - Runs concurrently with the next EVEN line.
  - Read of entry k always precedes the write of entry k for the next line (see Timing), so one bank per line is sufficient.
- busy_o drops the cycle after the last hsync_o of row pair FRAME_HEIGHT/2-1.
- Reset values: all outputs 0, FSM = IDLE, counters 0, burst inactive. Buffer contents are don't-care.
- Reset mid-frame or mid-burst: outputs go to 0 immediately; the next accepted sof restarts cleanly.

## Timing
- Last odd pixel accepted at edge t:
  - rd_addr 0 is presented at t+1;
  - hsync_o is high on cycles t+2 .. t+1+FRAME_WIDTH/2;
  - quad k appears at t+2+k.
- Next even line: pair k is written no earlier than edge t+2+2k, while its read occurs at edge t+1+k. Read-before-write holds for any k >= 0.
- hsync_o is low for at least FRAME_WIDTH/2 cycles between bursts, which guarantees the rising edge the downstream core detects.
- vsync_o: high on cycle s+1 for an sof accepted at edge s.
- No backpressure. The downstream core must accept every burst cycle.

## Configuration
- QPACK_RESYNC_EN defined: sof_i accepted in EVEN or ODD aborts the current frame.
  - Counters reset and that pixel becomes (0,0).
  - Any burst already in progress completes unchanged.
  - vsync_o pulses again.
- QPACK_RESYNC_EN undefined: sof_i is honoured only in IDLE. Mid-frame it is ignored and the pixel is treated as ordinary data.

## Test plan
- 40x16 frame, p(x,y) = (40y+x) mod 256, gapless:
  - 8 bursts of 20 cycles each;
  - first quad 0x00012829;
  - last quad of burst 0 is 0x26274E4F;
  - hsync_o first rises 2 cycles after pixel (39,1).
- Same frame, pix_valid_i toggling 1-0: identical quad sequence. Each burst is still 20 contiguous cycles.
- Two back-to-back frames with no idle gap:
  - vsync_o pulses once per frame;
  - busy_o stays high across the boundary;
  - second frame's quads are correct, with no read/write corruption.
- rst_n asserted mid-burst (quad 10 of row pair 3):
  - hsync_o, data_o, vsync_o, busy_o go to 0 asynchronously;
  - a new sof then produces a correct full frame.
- sof_i at pixel (5,6):
  - with QPACK_RESYNC_EN: new frame starts and vsync_o pulses;
  - without it: the pixel is data and the original frame completes with 8 bursts.
- FRAME_WIDTH=4, FRAME_HEIGHT=2, pixels 1..8: one 2-cycle burst carrying quads 0x01020506 and 0x03040708.
